// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, line/frame total helpers and the pixel-control bundle
// carried down the read-latency delay line.
package vga_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  function automatic int h_total(input int act, input int fp, input int syn, input int bp);
    return act + fp + syn + bp;
  endfunction

  function automatic int v_total(input int act, input int fp, input int syn, input int bp);
    return act + fp + syn + bp;
  endfunction

  typedef struct packed {
    logic hs;
    logic vs;
    logic vis;
    logic win;
    logic brd;
  } pix_ctrl_t;

  // Idle bundle: syncs deasserted, nothing visible.
  localparam pix_ctrl_t PIX_IDLE = '{hs: 1'b1, vs: 1'b1, vis: 1'b0, win: 1'b0, brd: 1'b0};

endpackage

// File: rtl/vga_timing_gen.sv
// Free-running raster counters with raw active-low syncs, visible flag and frame-start strobe.
// Zero latency: outputs describe the current counter state; no backpressure.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter int HW       = $clog2(h_total(H_ACTIVE, H_FP, H_SYNC, H_BP) + 1),
  parameter int VW       = $clog2(v_total(V_ACTIVE, V_FP, V_SYNC, V_BP) + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  output logic [HW-1:0] hc_o,
  output logic [VW-1:0] vc_o,
  output logic          hsync_o,
  output logic          vsync_o,
  output logic          visible_o,
  output logic          frame_start_o
);

  localparam int HT  = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int VT  = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int HS0 = H_ACTIVE + H_FP;
  localparam int HS1 = HS0 + H_SYNC;
  localparam int VS0 = V_ACTIVE + V_FP;
  localparam int VS1 = VS0 + V_SYNC;

  logic [HW-1:0] hc_q, hc_d;
  logic [VW-1:0] vc_q, vc_d;

  always_comb begin
    hc_d = hc_q + 1'b1;
    vc_d = vc_q;
    if (hc_q == HW'(HT - 1)) begin
      hc_d = '0;
      vc_d = (vc_q == VW'(VT - 1)) ? '0 : vc_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hc_q <= '0;
      vc_q <= '0;
    end else begin
      hc_q <= hc_d;
      vc_q <= vc_d;
    end
  end

  assign hc_o          = hc_q;
  assign vc_o          = vc_q;
  assign hsync_o       = ~((hc_q >= HW'(HS0)) && (hc_q < HW'(HS1)));
  assign vsync_o       = ~((vc_q >= VW'(VS0)) && (vc_q < VW'(VS1)));
  assign visible_o     = (hc_q < HW'(H_ACTIVE)) && (vc_q < VW'(V_ACTIVE));
  assign frame_start_o = (hc_q == '0) && (vc_q == '0);

endmodule

// File: rtl/vga_frame_reader.sv
// Streams a window of an N-image grayscale frame buffer to the VGA DAC; sync and colour leave
// RD_LAT+2 clocks after the counter state, no backpressure. Build with VGA_BORDER_EN for a 1-pixel white frame.
module vga_frame_reader
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter int IMG_W    = 460,
  parameter int IMG_H    = 460,
  parameter int N_IMG    = 2,
  parameter int X0       = 90,
  parameter int Y0       = 10,
  parameter int RD_LAT   = 1,
  parameter int BG_GRAY  = 0,
  parameter int AW       = $clog2(IMG_W * IMG_H * N_IMG),
  parameter int IW       = (N_IMG > 1) ? $clog2(N_IMG) : 1
) (
  input  logic          clk_25,
  input  logic          rst_n,
  input  logic          enter,
  output logic [AW-1:0] pixel_address,
  input  logic [7:0]    pixel_data,
  output logic          vga_hsync,
  output logic          vga_vsync,
  output logic          sync_blank,
  output logic          sync_b,
  output logic [7:0]    red,
  output logic [7:0]    green,
  output logic [7:0]    blue,
  output logic [IW-1:0] img_idx,
  output logic          frame_start
);

  localparam int HW = $clog2(h_total(H_ACTIVE, H_FP, H_SYNC, H_BP) + 1);
  localparam int VW = $clog2(v_total(V_ACTIVE, V_FP, V_SYNC, V_BP) + 1);

  if ((X0 + IMG_W > H_ACTIVE) || (Y0 + IMG_H > V_ACTIVE)) begin : g_win_chk
    $error("vga_frame_reader: image window does not fit in the active area");
  end
  if ((RD_LAT < 1) || (RD_LAT > 4)) begin : g_lat_chk
    $error("vga_frame_reader: RD_LAT must be 1..4");
  end

  logic [HW-1:0] hc;
  logic [VW-1:0] vc;
  logic          hs_raw, vs_raw, vis, fs;

  vga_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HW(HW), .VW(VW)
  ) u_tgen (
    .clk_i(clk_25), .rst_ni(rst_n), .hc_o(hc), .vc_o(vc), .hsync_o(hs_raw),
    .vsync_o(vs_raw), .visible_o(vis), .frame_start_o(fs)
  );

  logic in_win, brd;
  assign in_win = vis && (hc >= HW'(X0)) && (hc < HW'(X0 + IMG_W))
                      && (vc >= VW'(Y0)) && (vc < VW'(Y0 + IMG_H));

`ifdef VGA_BORDER_EN
  logic on_col, on_row;
  // Integer compares keep X0-1 / Y0-1 meaningful when the window touches the edge.
  assign on_col = ((int'(hc) == X0 - 1) || (int'(hc) == X0 + IMG_W))
                  && (int'(vc) >= Y0 - 1) && (int'(vc) <= Y0 + IMG_H);
  assign on_row = ((int'(vc) == Y0 - 1) || (int'(vc) == Y0 + IMG_H))
                  && (int'(hc) >= X0 - 1) && (int'(hc) <= X0 + IMG_W);
  assign brd    = vis && (on_col || on_row);
`else
  assign brd = 1'b0;
`endif

  logic [1:0] sync_q;
  logic       prev_q, rise;
  logic       pend_q, pend_d, take;
  logic [IW-1:0] img_q, img_d, img_inc;

  assign rise    = sync_q[1] & ~prev_q;
  // An edge landing on the frame-start clock is consumed by that same frame start.
  assign take    = fs && (pend_q || rise);
  assign pend_d  = fs ? 1'b0 : (pend_q | rise);
  assign img_inc = (img_q == IW'(N_IMG - 1)) ? '0 : img_q + 1'b1;
  assign img_d   = take ? img_inc : img_q;

  logic [AW-1:0] base_nxt, row_cur, row_base_q, row_base_d, addr_q, addr_d;

  always_comb begin
    base_nxt = '0;
    for (int i = 0; i < N_IMG; i++) begin
      if (img_d == IW'(i)) base_nxt = AW'(i * IMG_W * IMG_H);
    end
  end

  always_comb begin
    row_cur    = fs ? base_nxt : row_base_q;
    row_base_d = row_cur;
    addr_d     = addr_q;
    if (in_win) begin
      addr_d = row_cur + AW'(hc - HW'(X0));
      if (hc == HW'(X0 + IMG_W - 1)) row_base_d = row_cur + AW'(IMG_W);
    end
  end

  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= '0;
      prev_q     <= 1'b0;
      pend_q     <= 1'b0;
      img_q      <= '0;
      row_base_q <= '0;
      addr_q     <= '0;
    end else begin
      sync_q     <= {sync_q[0], enter};
      prev_q     <= sync_q[1];
      pend_q     <= pend_d;
      img_q      <= img_d;
      row_base_q <= row_base_d;
      addr_q     <= addr_d;
    end
  end

  pix_ctrl_t ctrl, pc;
  pix_ctrl_t dly_q [RD_LAT+1];

  assign ctrl = '{hs: hs_raw, vs: vs_raw, vis: vis, win: in_win, brd: brd};
  assign pc   = dly_q[RD_LAT];

  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= RD_LAT; i++) dly_q[i] <= PIX_IDLE;
    end else begin
      dly_q[0] <= ctrl;
      for (int i = 1; i <= RD_LAT; i++) dly_q[i] <= dly_q[i-1];
    end
  end

  logic [7:0] gray_d, gray_q;
  logic       hs_q, vs_q, blank_q, fs_q;

  always_comb begin
    gray_d = 8'h00;
    if (pc.vis) begin
      if (pc.brd)      gray_d = 8'hFF;
      else if (pc.win) gray_d = pixel_data;
      else             gray_d = 8'(BG_GRAY);
    end
  end

  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      blank_q <= 1'b0;
      gray_q  <= 8'h00;
      fs_q    <= 1'b0;
    end else begin
      hs_q    <= pc.hs;
      vs_q    <= pc.vs;
      blank_q <= pc.vis;
      gray_q  <= gray_d;
      fs_q    <= fs;
    end
  end

  assign pixel_address = addr_q;
  assign vga_hsync     = hs_q;
  assign vga_vsync     = vs_q;
  assign sync_blank    = blank_q;
  assign sync_b        = 1'b0;
  assign red           = gray_q;
  assign green         = gray_q;
  assign blue          = gray_q;
  assign img_idx       = img_q;
  assign frame_start   = fs_q;

endmodule

// File: tb/tb_vga_frame_reader.sv
// Scoreboard bench for vga_frame_reader on a shrunken 24x17 raster with a 6x5 window at (4,3),
// two images and a 2-clock RAM model returning addr[7:0].
module tb_vga_frame_reader;

  localparam int H_ACTIVE = 16, H_FP = 2, H_SYNC = 3, H_BP = 3;
  localparam int V_ACTIVE = 12, V_FP = 1, V_SYNC = 2, V_BP = 2;
  localparam int IMG_W = 6, IMG_H = 5, N_IMG = 2, X0 = 4, Y0 = 3;
  localparam int RD_LAT = 2, BG_GRAY = 8'h11, AW = 6, IW = 1;
`ifdef VGA_BORDER_EN
  localparam int BRD = 8'hFF;
`else
  localparam int BRD = 8'h11;
`endif

  logic          clk_25 = 1'b0;
  logic          rst_n  = 1'b0;
  logic          enter  = 1'b0;
  logic [AW-1:0] pixel_address;
  logic [7:0]    pixel_data;
  logic          vga_hsync, vga_vsync, sync_blank, sync_b, frame_start;
  logic [7:0]    red, green, blue;
  logic [IW-1:0] img_idx;

  vga_frame_reader #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .IMG_W(IMG_W), .IMG_H(IMG_H), .N_IMG(N_IMG), .X0(X0), .Y0(Y0),
    .RD_LAT(RD_LAT), .BG_GRAY(BG_GRAY), .AW(AW), .IW(IW)
  ) dut (
    .clk_25(clk_25), .rst_n(rst_n), .enter(enter), .pixel_address(pixel_address),
    .pixel_data(pixel_data), .vga_hsync(vga_hsync), .vga_vsync(vga_vsync),
    .sync_blank(sync_blank), .sync_b(sync_b), .red(red), .green(green), .blue(blue),
    .img_idx(img_idx), .frame_start(frame_start)
  );

  initial forever #20 clk_25 = ~clk_25;

  // RAM with two clocks of read latency, q = address.
  logic [AW-1:0] ram_p1, ram_p2;
  always @(posedge clk_25) begin
    ram_p1 <= pixel_address;
    ram_p2 <= ram_p1;
  end
  assign pixel_data = 8'(ram_p2);

  // Cycle index since reset release; counter state k reaches the pins in cycle k+4.
  int cyc;
  always @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  typedef struct packed {
    int         cyc;
    logic       hs;
    logic       vs;
    logic       blk;
    logic [7:0] rgb;
    logic [IW-1:0] img;
    logic       fs;
  } exp_t;

  exp_t  sb[$];
  string sb_name[$];
  int    total = 0;
  int    bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input int c, input string n, input bit hs, input bit vs, input bit blk,
                      input int rgb, input int img, input bit fs);
    exp_t e;
    e.cyc = c; e.hs = hs; e.vs = vs; e.blk = blk;
    e.rgb = 8'(rgb); e.img = IW'(img); e.fs = fs;
    sb.push_back(e);
    sb_name.push_back(n);
  endtask

  task automatic reset_checks(input string p);
    chk({p, "_hsync"}, vga_hsync, 1);
    chk({p, "_vsync"}, vga_vsync, 1);
    chk({p, "_blank"}, sync_blank, 0);
    chk({p, "_sync_b"}, sync_b, 0);
    chk({p, "_red"}, red, 0);
    chk({p, "_green"}, green, 0);
    chk({p, "_blue"}, blue, 0);
    chk({p, "_img"}, img_idx, 0);
    chk({p, "_addr"}, pixel_address, 0);
    chk({p, "_fs"}, frame_start, 0);
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) @(negedge clk_25);
  endtask

  // Monitor: pops every expectation whose cycle has come and compares the pins.
  initial begin
    exp_t  e;
    string n;
    forever begin
      @(negedge clk_25);
      if (rst_n) begin
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
          e = sb.pop_front(); n = sb_name.pop_front();
          total++; bad++;
          $display("FAIL %s: checked at cycle %0d, required cycle %0d", n, cyc, e.cyc);
        end
        while (sb.size() > 0 && sb[0].cyc == cyc) begin
          e = sb.pop_front(); n = sb_name.pop_front();
          chk({n, ".hsync"}, vga_hsync, e.hs);
          chk({n, ".vsync"}, vga_vsync, e.vs);
          chk({n, ".blank"}, sync_blank, e.blk);
          chk({n, ".sync_b"}, sync_b, 0);
          chk({n, ".red"}, red, e.rgb);
          chk({n, ".green"}, green, e.rgb);
          chk({n, ".blue"}, blue, e.rgb);
          chk({n, ".img"}, img_idx, e.img);
          chk({n, ".fs"}, frame_start, e.fs);
        end
      end
    end
  end

  initial begin
    #(40 * 6000);
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    enter = 1'b0;
    repeat (3) @(posedge clk_25);
    #5;
    reset_checks("rst0");

    //   cycle name             hs vs blk rgb    img fs
    push(1,    "fs0",           1, 1, 0, 0,     0, 1);
    push(2,    "fs_low",        1, 1, 0, 0,     0, 0);
    push(4,    "vis_first",     1, 1, 1, 8'h11, 0, 0);
    push(19,   "last_vis",      1, 1, 1, 8'h11, 0, 0);
    push(20,   "blank_fp",      1, 1, 0, 0,     0, 0);
    push(21,   "hs_pre",        1, 1, 0, 0,     0, 0);
    push(22,   "hs_start",      0, 1, 0, 0,     0, 0);
    push(24,   "hs_end",        0, 1, 0, 0,     0, 0);
    push(25,   "hs_post",       1, 1, 0, 0,     0, 0);
    push(55,   "corner",        1, 1, 1, BRD,   0, 0);
    push(61,   "above_win",     1, 1, 1, BRD,   0, 0);
    push(79,   "win_left_out",  1, 1, 1, BRD,   0, 0);
    push(80,   "win_first",     1, 1, 1, 0,     0, 0);
    push(85,   "win_row0_end",  1, 1, 1, 5,     0, 0);
    push(86,   "win_right_out", 1, 1, 1, BRD,   0, 0);
    push(104,  "win_row1",      1, 1, 1, 6,     0, 0);
    push(136,  "bg_far",        1, 1, 1, 8'h11, 0, 0);
    push(181,  "win_last",      1, 1, 1, 29,    0, 0);
    push(200,  "below_win",     1, 1, 1, BRD,   0, 0);
    push(292,  "vs_pre",        1, 1, 0, 0,     0, 0);
    push(316,  "vs_start",      1, 0, 0, 0,     0, 0);
    push(334,  "vs_hs",         0, 0, 0, 0,     0, 0);
    push(363,  "vs_end",        1, 0, 0, 0,     0, 0);
    push(364,  "vs_post",       1, 1, 0, 0,     0, 0);
    push(409,  "fs1",           1, 1, 0, 0,     1, 1);
    push(488,  "img1_first",    1, 1, 1, 30,    1, 0);
    push(538,  "img1_mid",      1, 1, 1, 44,    1, 0);
    push(589,  "img1_last",     1, 1, 1, 59,    1, 0);
    push(817,  "fs2",           1, 1, 0, 0,     0, 1);
    push(896,  "img2_first",    1, 1, 1, 0,     0, 0);
    push(946,  "img2_mid",      1, 1, 1, 14,    0, 0);
    push(1225, "fs3",           1, 1, 0, 0,     1, 1);
    push(1304, "img3_first",    1, 1, 1, 30,    1, 0);
    push(1354, "pre_rst",       1, 1, 1, 44,    1, 0);

    @(negedge clk_25);
    rst_n = 1'b1;

    // Two presses in frame 0 collapse to one advance at frame 1.
    wait_until(100);  enter = 1'b1;
    wait_until(103);  enter = 1'b0;
    wait_until(200);  enter = 1'b1;
    wait_until(203);  enter = 1'b0;
    // Synchronised edge lands exactly on the frame-2 start clock.
    wait_until(814);  enter = 1'b1;
    wait_until(820);  enter = 1'b0;
    wait_until(900);  enter = 1'b1;
    wait_until(903);  enter = 1'b0;

    wait_until(1354);
    #2 rst_n = 1'b0;
    #1 reset_checks("rst_mid");

    repeat (2) @(posedge clk_25);
    push(1,  "rst2_fs",  1, 1, 0, 0,     0, 1);
    push(4,  "rst2_vis", 1, 1, 1, 8'h11, 0, 0);
    push(22, "rst2_hs",  0, 1, 0, 0,     0, 0);
    push(80, "rst2_win", 1, 1, 1, 0,     0, 0);
    @(negedge clk_25);
    rst_n = 1'b1;
    wait_until(100);

    while (sb.size() > 0) begin
      exp_t  e;
      string n;
      e = sb.pop_front(); n = sb_name.pop_front();
      total++; bad++;
      $display("FAIL %s: never reached, required cycle %0d", n, e.cyc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_frame_reader.md
Name: vga_frame_reader

Overview:
Parametrised successor to the fixed 460x460 VGA painter. It merges the timing generator and the painter into one block, which streams a window of an N-image grayscale frame buffer to the DAC.
- Read latency: the frame-buffer RAM read latency is a parameter; sync, blank and colour outputs are pipelined so they stay aligned with returned pixel data.
- Image select: the `enter` button selects the next image. The switch always happens on a frame boundary, so images never tear.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (clocks)
H_SYNC, 96, hsync pulse width (clocks)
H_BP, 48, horizontal back porch (clocks)
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines)
IMG_W, 460, image width (pixels)
IMG_H, 460, image height (pixels)
N_IMG, 2, images stored back to back in RAM
X0, 90, window left column (visible coordinates)
Y0, 10, window top line (visible coordinates)
RD_LAT, 1, RAM clocks from address to q (1..4)
BG_GRAY, 0, 8-bit gray level outside the window
AW, $clog2(IMG_W*IMG_H*N_IMG), address width (19 at defaults)

Ports:
clk_25  in  1  pixel clock
rst_n  in  1  asynchronous active-low reset
enter  in  1  raw button, asynchronous, active high
pixel_address  out  AW  frame-buffer read address
pixel_data  in  8  RAM q, valid RD_LAT clocks after address
vga_hsync  out  1  horizontal sync, active low
vga_vsync  out  1  vertical sync, active low
sync_blank  out  1  DAC BLANK_n, high in visible area
sync_b  out  1  DAC SYNC_n, tied 0
red, green, blue  out  8 each  gray replicated to all channels
img_idx  out  $clog2(N_IMG) (min 1)  image currently displayed
frame_start  out  1  one-clock pulse when hc=0 and vc=0

Behaviour:
- Counters:
  - hc counts 0..H_TOTAL-1 and wraps; H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP.
  - vc advances when hc wraps; V_TOTAL is defined the same way.
  - Visible region: hc<H_ACTIVE and vc<V_ACTIVE.
  - Raw hsync is low for hc in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); vsync is defined likewise on vc.
- Window: in_win = visible, X0<=hc<X0+IMG_W, and Y0<=vc<Y0+IMG_H.
- Addressing: incremental, no multiplier.
  - base = img_idx*IMG_W*IMG_H; computed as a constant mux or accumulated.
  - row_base resets to base at frame start and adds IMG_W at the end of each window line.
  - pixel_address = row_base + (hc-X0) while in_win. Outside the window it holds its last value.
  - pixel_address is registered, so it appears 1 clock after the counter state.
- Alignment:
  - raw hsync, vsync, visible and in_win pass through a delay line of RD_LAT+1 stages.
  - Outputs are registered.
  - Total latency from counter state to output pins is RD_LAT+2 clocks, the same for sync and colour.
- Colour: delayed in_win selects pixel_data; otherwise BG_GRAY. When delayed visible=0, rgb=0.
- Enter:
  - 2-FF synchroniser, then rising-edge detect, sets a pend flag.
  - At frame_start with pend=1: img_idx <= (img_idx==N_IMG-1) ? 0 : img_idx+1, and pend clears.
  - An edge arriving in the same clock as frame_start is applied at that frame start.
  - Multiple edges within one frame collapse to a single advance.
- Reset (any time, including mid-frame):
  - hc=vc=0, img_idx=0, pend=0, delay line cleared.
  - vga_hsync=1, vga_vsync=1, sync_blank=0, sync_b=0, rgb=0.
  - pixel_address=0, frame_start=0.
- Elaboration check: the window must fit in the active area (X0+IMG_W<=H_ACTIVE, Y0+IMG_H<=V_ACTIVE); a violation fails elaboration via $error.

Optional Feature:
VGA_BORDER_EN:
- Defined: a 1-pixel frame at hc=X0-1, hc=X0+IMG_W, vc=Y0-1 and vc=Y0+IMG_H is drawn in gray 255. It applies only inside the visible area and is delay-aligned like in_win.
- Undefined: those pixels show BG_GRAY.
- The enable is a compile-time macro; no border logic exists without it.

Decomposition:
- Package vga_pkg: timing parameter defaults, H_TOTAL/V_TOTAL functions, and a typedef struct {hs, vs, vis, win, brd} for the pixel-control bundle carried by the delay line.
- One sub-module, vga_timing_gen: hc, vc, raw syncs, visible and frame_start, reused by future overlay blocks.

Test Plan:
1. Reset -> hsync=vsync=1, blank=0, rgb=0, img_idx=0. Release, run 1 line -> hsync low for exactly 96 clocks starting 656+RD_LAT+2 clocks after hc=0.
2. RAM model with q=addr[7:0], RD_LAT=2 -> first window pixel on the DAC at line 10, column 90 with value 0. Address 211599 appears on line 469; window-edge pixels match addr&0xFF; outside the window rgb=0.
3. enter pulse mid-frame 0 -> img_idx becomes 1 at the next frame_start; first address that frame is 211600. A second pulse in the same frame has no extra effect.
4. Two enter pulses over two frames with N_IMG=2 -> img_idx goes 0→1→0. The enter edge coinciding with frame_start switches in that frame.
5. Reset asserted at line 200 -> outputs return to reset values asynchronously. After release, timing restarts at hc=vc=0 and addressing restarts at 0.
6. VGA_BORDER_EN defined -> gray 255 at (89,10..469) and (550,y); with the macro undefined, 0 at the same pixels.
